// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter slice: FSM encoding, the
// busy-acknowledge timeout and the TX8 baud divisor constants.
package uart_pkg;

    // Arbiter FSM encoding (2-bit)
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    // Cycles to wait in WAIT_BUSY for TX8 to acknowledge a start pulse
    localparam int BUSY_TIMEOUT = 4;

    // TX8 divisors at 24 MHz (clocks per bit)
    localparam int DIV_115200 = 208;
    localparam int DIV_9600   = 2500;
    localparam int DIV_SIM    = 10;

    // TX8 frame: 1 start bit, 8 data bits, 2 stop bits
    localparam int FRAME_BITS = 11;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit bundle between byte producers, the arbiter and TX8.
// Optional member req_lock exists only when UART_TX_ARB_LOCK_EN is defined.
//
// Handshake: req_valid[i] rises when requester i has a byte and stays high,
// with req_data[8*i+7:8*i] stable, until the single-cycle req_ready[i] pulse;
// the byte is accepted on that cycle. tx_start is a one-cycle pulse to TX8,
// tx_data is held until TX8 drops tx_busy after the frame.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
`ifdef UART_TX_ARB_LOCK_EN
    logic [N_REQ-1:0]   req_lock;
`endif
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic [IDW-1:0]     gnt_id;
    logic               active;

`ifdef UART_TX_ARB_LOCK_EN
    modport slave  (input  req_valid, req_data, req_lock, tx_busy,
                    output req_ready, tx_start, tx_data, gnt_id, active);
    modport master (output req_valid, req_data, req_lock, tx_busy,
                    input  req_ready, tx_start, tx_data, gnt_id, active);
`else
    modport slave  (input  req_valid, req_data, tx_busy,
                    output req_ready, tx_start, tx_data, gnt_id, active);
    modport master (output req_valid, req_data, tx_busy,
                    input  req_ready, tx_start, tx_data, gnt_id, active);
`endif

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, with wrap.
// last_i itself is checked last, so a sole requester is picked again.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   last_i,
    output logic [IDW-1:0]   win_o,
    output logic             any_o
);

    logic [IDW-1:0] idx;

    // Scan farthest-first so the nearest request after last_i wins
    always_comb begin
        win_o = last_i;
        any_o = 1'b0;
        idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IDW'((int'(last_i) + k) % N_REQ);
            if (req_i[idx]) begin
                win_o = idx;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one TX8 transmitter among N_REQ byte sources.
// One byte per grant; tx_data is latched at grant and held for the frame.
// IDW must equal clog2(N_REQ).
// Build option UART_TX_ARB_LOCK_EN: adds req_lock so a requester that had
// lock set when its byte was accepted keeps the grant while still valid.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus,
    output state_t           state_o
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [7:0]       data_q, data_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [N_REQ-1:0] ready;
    logic             start;
    logic [IDW-1:0]   rr_win;
    logic [IDW-1:0]   pick;
    logic             rr_any;
`ifdef UART_TX_ARB_LOCK_EN
    logic             lock_q, lock_d;
`endif

    rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
        .req_i (bus.req_valid),
        .last_i(gnt_q),
        .win_o (rr_win),
        .any_o (rr_any)
    );

`ifdef UART_TX_ARB_LOCK_EN
    // A locked channel keeps the transmitter as long as it still has data
    assign pick = (lock_q && bus.req_valid[gnt_q]) ? gnt_q : rr_win;
`else
    assign pick = rr_win;
`endif

    // State, grant, held byte and timeout counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= IDW'(N_REQ - 1);
            data_q  <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    // Lock flag of the most recently accepted byte
    always_ff @(posedge clk) begin
        if (rst) lock_q <= 1'b0;
        else     lock_q <= lock_d;
    end
`endif

    // Next-state and handshake outputs
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ready   = '0;
        start   = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d  = lock_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A TX8 still busy (e.g. after an arbiter-only reset) blocks grants
                if (!bus.tx_busy && rr_any) begin
                    gnt_d   = pick;
                    data_d  = bus.req_data[{pick, 3'b000} +: 8];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start      = 1'b1;
                ready[gnt_q] = 1'b1;
                cnt_d      = '0;
`ifdef UART_TX_ARB_LOCK_EN
                lock_d     = bus.req_lock[gnt_q];
`endif
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // No acknowledge in time: the byte is dropped, no retry
                if (bus.tx_busy)                           state_d = S_WAIT_DONE;
                else if (cnt_q == 3'(BUSY_TIMEOUT - 1))    state_d = S_IDLE;
                else                                       cnt_d   = cnt_q + 3'd1;
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready = ready;
    assign bus.tx_start  = start;
    assign bus.tx_data   = data_q;
    assign bus.gnt_id    = gnt_q;
    assign bus.active    = (state_q != S_IDLE);
    assign state_o       = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural TX8 (divisor DIV_SIM), per-channel
// byte queues as requesters, and a cycle-level reference model of the grant
// rules and frame timing. Honours UART_TX_ARB_LOCK_EN.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N_REQ     = 4;
  localparam int IDW       = 2;
  localparam int FRAME     = FRAME_BITS * DIV_SIM;   // TX8 busy cycles per byte
  localparam int ACT_ALIVE = FRAME + 2;              // ISSUE + WAIT_BUSY + WAIT_DONE
  localparam int ACT_DEAD  = BUSY_TIMEOUT + 1;       // ISSUE + timed-out WAIT_BUSY

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   rst_req = 1'b1;
  state_t dbg_state;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .IDW(IDW)) bus ();

  uart_tx_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .state_o(dbg_state)
  );

  // ---------------- bench state ----------------
  logic [8:0] ch_q [N_REQ][$];     // {lock, byte} per requester
  logic [7:0] exp_q [$];           // bytes TX8 is expected to send, in order
  logic [7:0] sent_log [$];
  int         gnt_log [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;

  // reference model
  int         m_last   = N_REQ - 1;
  bit         m_lock   = 1'b0;
  int         act_left = 0;
  bit         m_idle   = 1'b1;
  bit         issue_pend = 1'b0;
  int         issue_w  = 0;
  logic [7:0] issue_d  = 8'h00;
  bit         pop_pend = 1'b0;
  int         pop_ch   = 0;
  int         since_issue = 0;

  // behavioural TX8
  bit         tx8_dead = 1'b0;
  bit         tx8_busy = 1'b0;
  bit         tx8_pend = 1'b0;
  bit         tx8_rst_seen = 1'b0;
  int         tx8_cnt  = 0;
  logic [7:0] tx8_byte = 8'h00;

  int exp_ord2 [5] = '{0, 1, 2, 3, 0};
`ifdef UART_TX_ARB_LOCK_EN
  int exp_ord7 [4] = '{3, 3, 3, 0};
`else
  int exp_ord7 [4] = '{3, 0, 3, 3};
`endif

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // First valid requester after 'last' going upward with wrap; -1 if none
  function automatic int rr_model(input logic [N_REQ-1:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++)
      if (((v >> ((last + k) % N_REQ)) & 1) != 0) return (last + k) % N_REQ;
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_inputs();
    logic [N_REQ-1:0]   v;
    logic [8*N_REQ-1:0] d;
    logic [N_REQ-1:0]   l;
    v = '0; d = '0; l = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ch_q[i].size() > 0) begin
        v[i] = 1'b1;
        d = d | ((8*N_REQ)'(ch_q[i][0][7:0]) << (8*i));
        l[i] = ch_q[i][0][8];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
`ifdef UART_TX_ARB_LOCK_EN
    bus.req_lock  = l;
`endif
    bus.tx_busy   = tx8_busy;
    rst           = rst_req;
  endtask

  // One clock: check outputs at negedge, step TX8 and requesters, predict
  task automatic cycle();
    int w;
    @(negedge clk);
    cyc++;
    // requester releases the byte one edge after its ready pulse
    if (pop_pend) begin
      void'(ch_q[pop_ch].pop_front());
      pop_pend = 1'b0;
    end

    if (rst) begin
      chk("rst_start",  bus.tx_start, 0);
      chk("rst_ready",  bus.req_ready, 0);
      chk("rst_data",   bus.tx_data, 8'h00);
      chk("rst_gnt",    bus.gnt_id, N_REQ - 1);
      chk("rst_active", bus.active, 0);
      m_last = N_REQ - 1; m_lock = 1'b0; act_left = 0; issue_pend = 1'b0; m_idle = 1'b1;
      if (tx8_busy || tx8_pend) tx8_rst_seen = 1'b1;
    end else if (issue_pend) begin
      chk("start",  bus.tx_start, 1);
      chk("ready",  bus.req_ready, 32'(1) << issue_w);
      chk("gnt",    bus.gnt_id, issue_w);
      chk("data",   bus.tx_data, issue_d);
      chk("active", bus.active, 1);
      m_last = issue_w;
`ifdef UART_TX_ARB_LOCK_EN
      m_lock = ((bus.req_lock >> issue_w) & 1) != 0;
`endif
      act_left = tx8_dead ? ACT_DEAD - 1 : ACT_ALIVE - 1;
      if (!tx8_dead) exp_q.push_back(issue_d);
      gnt_log.push_back(issue_w);
      pop_ch = issue_w; pop_pend = 1'b1;
      issue_pend = 1'b0; since_issue = 0; m_idle = 1'b0;
    end else begin
      chk("no_start", bus.tx_start, 0);
      chk("no_ready", bus.req_ready, 0);
      chk("active",   bus.active, act_left > 0);
      m_idle = (act_left == 0);
      if (act_left > 0) act_left--;
      since_issue++;
    end

    // TX8: busy rises the cycle after start, lasts one frame
    if (tx8_busy) begin
      tx8_cnt--;
      if (tx8_cnt == 0) begin
        if (!tx8_rst_seen) chk("hold", bus.tx_data, tx8_byte);
        chk("sb_depth", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("sb_byte", tx8_byte, exp_q.pop_front());
        tx8_busy = 1'b0;
      end
    end
    if (tx8_pend) begin
      tx8_busy = 1'b1; tx8_cnt = FRAME; tx8_pend = 1'b0;
    end
    if (bus.tx_start === 1'b1 && !tx8_dead && !tx8_busy) begin
      tx8_pend = 1'b1; tx8_byte = bus.tx_data; tx8_rst_seen = 1'b0;
      sent_log.push_back(bus.tx_data);
    end

    drive_inputs();

    // Model: an IDLE arbiter grants on the next edge if TX8 is free
    if (!rst && m_idle && !bus.tx_busy && bus.req_valid != 0) begin
      w = rr_model(bus.req_valid, m_last);
      if (m_lock && ((bus.req_valid >> m_last) & 1) != 0) w = m_last;
      issue_pend = 1'b1;
      issue_w    = w;
      issue_d    = 8'(bus.req_data >> (8*w));
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N_REQ; i++) if (ch_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(all_empty() && act_left == 0 && !issue_pend && !pop_pend &&
             !tx8_busy && !tx8_pend) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", n < budget, 1);
  endtask

  task automatic pulse_reset();
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int n;
    int m;
    drive_inputs();
    // 1: reset, then a lone byte on ch2
    repeat (3) cycle();
    rst_req = 1'b0;
    cycle();
    ch_q[2].push_back({1'b0, 8'hA5});
    drain(2000);
    chk("t1_count", sent_log.size(), 1);
    if (sent_log.size() > 0) chk("t1_byte", sent_log[0], 8'hA5);

    // 2: all four valid after reset -> 0,1,2,3,0 back to back
    pulse_reset();
    gnt_log.delete();
    ch_q[0].push_back({1'b0, 8'h10}); ch_q[0].push_back({1'b0, 8'h14});
    ch_q[1].push_back({1'b0, 8'h11});
    ch_q[2].push_back({1'b0, 8'h12});
    ch_q[3].push_back({1'b0, 8'h13});
    drain(3000);
    chk("t2_len", gnt_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < gnt_log.size()) chk("t2_order", gnt_log[i], exp_ord2[i]);

    // 3: ch1 data changes mid-frame of ch0 before ch1 is granted
    sent_log.delete();
    ch_q[0].push_back({1'b0, 8'h20});
    repeat (20) cycle();
    ch_q[1].push_back({1'b0, 8'h31});
    repeat (30) cycle();
    ch_q[1][0] = {1'b0, 8'h77};
    drain(2000);
    chk("t3_len", sent_log.size(), 2);
    if (sent_log.size() > 1) begin
      chk("t3_ch0", sent_log[0], 8'h20);
      chk("t3_ch1", sent_log[1], 8'h77);
    end

    // 4: TX8 never acknowledges -> timeouts, next requester re-granted
    tx8_dead = 1'b1;
    gnt_log.delete();
    ch_q[2].push_back({1'b0, 8'h42});
    ch_q[3].push_back({1'b0, 8'h43});
    drain(200);
    chk("t4_grants", gnt_log.size(), 2);
    tx8_dead = 1'b0;

    // 5: reset at cycle 50 of a frame; pending ch0/ch3 then ch0 wins
    ch_q[2].push_back({1'b0, 8'h5C});
    n = 0;
    while (!(tx8_busy && since_issue == 50) && n < 500) begin
      cycle(); n++;
    end
    chk("t5_reach", n < 500, 1);
    ch_q[3].push_back({1'b0, 8'h33});
    ch_q[0].push_back({1'b0, 8'h0C});
    gnt_log.delete();
    pulse_reset();
    drain(3000);
    chk("t5_len", gnt_log.size(), 2);
    if (gnt_log.size() > 0) chk("t5_first", gnt_log[0], 0);

    // 6: ch3 three-byte message (lock) while ch0 waits
    gnt_log.delete();
    ch_q[3].push_back({1'b1, 8'hC0});
    ch_q[3].push_back({1'b1, 8'hC1});
    ch_q[3].push_back({1'b0, 8'hC2});
    n = 0;
    while (gnt_log.size() == 0 && n < 50) begin
      cycle(); n++;
    end
    ch_q[0].push_back({1'b0, 8'h0F});
    drain(3000);
    chk("t6_len", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gnt_log.size()) chk("t6_order", gnt_log[i], exp_ord7[i]);

    // 7: random traffic with random locks and data changes
    for (int f = 0; f < 40; f++) begin
      c = $urandom_range(N_REQ - 1, 0);
      ch_q[c].push_back({1'($urandom_range(1, 0)), 8'($urandom_range(255, 0))});
      if ($urandom_range(3, 0) == 0)
        ch_q[(c + 1) % N_REQ].push_back({1'($urandom_range(1, 0)), 8'($urandom_range(255, 0))});
      n = $urandom_range(150, 0);
      for (int k = 0; k < n; k++) begin
        cycle();
        if ($urandom_range(40, 0) == 0) begin
          m = $urandom_range(N_REQ - 1, 0);
          if (ch_q[m].size() > 0) ch_q[m][0][7:0] = 8'($urandom_range(255, 0));
        end
      end
    end
    drain(30000);
    chk("sb_empty_end", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
